layer_featuremap_reduce: RTL and testbench

- Parametrised successor to the per-layer featuremap blocks.
- Takes NUM_CH per-channel 3x3 convolution results for one output pixel in parallel.
- Sums them in a pipelined adder tree, adds a per-featuremap bias, applies a selectable activation and saturates to DATA_WIDTH.
- Uses a valid/ready handshake with full backpressure and tracks pixel position within an IMG_SIZE x IMG_SIZE frame, flagging row and frame ends.
- Sits between the Conv2D3x3 channel bank of a layer and the next layer's line buffers.

---
 rtl/layer_pkg.sv | 42 ++++
 rtl/adder_tree_pipe.sv | 74 +++++++
 rtl/layer_featuremap_reduce.sv | 134 +++++++++++++
 tb/tb_layer_featuremap_reduce.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/layer_pkg.sv
// Shared definitions for the featuremap reduction datapath.
//   act_mode_t   : activation selector encoding
//   clog2        : elaboration-time ceiling log2 (clog2(1) = 0)
//   sat_to_width : clamp a wide signed value into a signed field of 'width' bits
package layer_pkg;

    typedef enum logic [1:0] {
        ACT_LINEAR = 2'd0,
        ACT_LEAKY  = 2'd1,
        ACT_RELU   = 2'd2
    } act_mode_t;

    // Width of the carrier used by sat_to_width; callers sign-extend into it.
    localparam int SAT_WIDTH = 64;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) begin
            r++;
        end
        return r;
    endfunction

    function automatic logic signed [SAT_WIDTH-1:0] sat_to_width(
        input logic signed [SAT_WIDTH-1:0] v,
        input int                          width
    );
        logic signed [SAT_WIDTH-1:0] hi;
        logic signed [SAT_WIDTH-1:0] lo;
        hi = (64'sd1 <<< (width - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (width - 1));
        if (v > hi) begin
            return hi;
        end
        if (v < lo) begin
            return lo;
        end
        return v;
    endfunction

endpackage

// File: rtl/adder_tree_pipe.sv
// Pipelined balanced adder tree.
//   Clk, Rst   : clock, synchronous active-low reset (clears valid bits only)
//   en         : global advance enable; when low every register holds
//   in_vec     : NUM_IN signed operands, operand k at [k*IN_WIDTH +: IN_WIDTH]
//   in_valid   : in_vec carries a pixel (qualified externally by en)
//   sum        : signed total, IN_WIDTH + clog2(NUM_IN) + 1 bits
//   sum_valid  : sum carries a pixel; clog2(NUM_IN) cycles behind in_valid
module adder_tree_pipe
    import layer_pkg::*;
#(
    parameter  int NUM_IN    = 16,
    parameter  int IN_WIDTH  = 16,
    localparam int LEVELS    = clog2(NUM_IN),
    localparam int SUM_WIDTH = IN_WIDTH + LEVELS + 1
) (
    input  logic                        Clk,
    input  logic                        Rst,
    input  logic                        en,
    input  logic [NUM_IN*IN_WIDTH-1:0]  in_vec,
    input  logic                        in_valid,
    output logic signed [SUM_WIDTH-1:0] sum,
    output logic                        sum_valid
);

    localparam int LEAVES = 1 << LEVELS;

    // Leaves are padded to a power of two; the padding leaves are constant 0.
    logic signed [SUM_WIDTH-1:0] leaf [LEAVES];

    for (genvar k = 0; k < LEAVES; k++) begin : g_leaf
        if (k < NUM_IN) begin : g_in
            assign leaf[k] = SUM_WIDTH'(signed'(in_vec[k*IN_WIDTH +: IN_WIDTH]));
        end else begin : g_pad
            assign leaf[k] = '0;
        end
    end

    if (LEVELS == 0) begin : g_pass
        assign sum       = leaf[0];
        assign sum_valid = in_valid;
    end else begin : g_tree
        // Heap-ordered internal nodes: node i has children 2i+1 and 2i+2;
        // indices past LEAVES-2 map onto leaf[] at offset LEAVES-1.
        logic signed [SUM_WIDTH-1:0] node_p [LEAVES-1];
        logic        [LEVELS-1:0]    vld_p;

        // ---- tree stages: one register level per tree depth ----
        always_ff @(posedge Clk) begin
            if (en) begin
                for (int i = 0; i < LEAVES/2 - 1; i++) begin
                    node_p[i] <= node_p[2*i+1] + node_p[2*i+2];
                end
                for (int i = LEAVES/2 - 1; i < LEAVES - 1; i++) begin
                    node_p[i] <= leaf[2*i+2-LEAVES] + leaf[2*i+3-LEAVES];
                end
            end
        end

        always_ff @(posedge Clk) begin
            if (!Rst) begin
                vld_p <= '0;
            end else if (en) begin
                vld_p[0] <= in_valid;
                for (int s = 1; s < LEVELS; s++) begin
                    vld_p[s] <= vld_p[s-1];
                end
            end
        end

        assign sum       = node_p[0];
        assign sum_valid = vld_p[LEVELS-1];
    end

endmodule

// File: rtl/layer_featuremap_reduce.sv
// Channel reduction for one output featuremap of a conv layer.
// Sums NUM_CH per-channel 3x3 results, adds BIAS, applies the selected
// activation, saturates to DATA_WIDTH and tags row/frame ends.
//   Clk, Rst   : clock, synchronous active-low reset
//   data_in    : NUM_CH signed channels, channel k at [k*DATA_WIDTH +: DATA_WIDTH]
//   valid_in   : data_in holds a pixel; taken when ready_out is high
//   ready_out  : block accepts data_in this cycle
//   data_out   : activated, saturated pixel
//   valid_out  : data_out valid; held until ready_in
//   ready_in   : downstream accepts data_out
//   row_end    : data_out is the last pixel of a row
//   frame_end  : data_out is the last pixel of the frame
module layer_featuremap_reduce
    import layer_pkg::*;
#(
    parameter int                           NUM_CH      = 16,
    parameter int                           DATA_WIDTH  = 16,
    parameter int                           FRAC_BITS   = 8,
    parameter int                           IMG_SIZE    = 208,
    parameter logic signed [DATA_WIDTH-1:0] BIAS        = '0,
    parameter int                           ACT_MODE    = 1,
    parameter int                           LEAKY_SHIFT = 3
) (
    input  logic                          Clk,
    input  logic                          Rst,
    input  logic [NUM_CH*DATA_WIDTH-1:0]  data_in,
    input  logic                          valid_in,
    output logic                          ready_out,
    output logic signed [DATA_WIDTH-1:0]  data_out,
    output logic                          valid_out,
    input  logic                          ready_in,
    output logic                          row_end,
    output logic                          frame_end
);

    localparam int        L          = clog2(NUM_CH);
    localparam int        ACC_WIDTH  = DATA_WIDTH + L + 1;
    localparam int        BIAS_WIDTH = ACC_WIDTH + 1;
    localparam act_mode_t ACT_SEL    = act_mode_t'(ACT_MODE);
    localparam int        CNT_W      = (IMG_SIZE > 1) ? clog2(IMG_SIZE) : 1;
    localparam logic [CNT_W-1:0] LAST_POS = CNT_W'(IMG_SIZE - 1);

    // FRAC_BITS only describes the Q format; arithmetic is plain integer.
    if (NUM_CH < 1 || FRAC_BITS < 0 || FRAC_BITS >= DATA_WIDTH || LEAKY_SHIFT < 0)
    begin : g_param_check
        $error("layer_featuremap_reduce: illegal parameter combination");
    end

    // Negative leaky values use >>>, i.e. floor toward -inf.
    function automatic logic signed [BIAS_WIDTH-1:0] apply_act(
        input logic signed [BIAS_WIDTH-1:0] v
    );
        case (ACT_SEL)
            ACT_RELU:  return v[BIAS_WIDTH-1] ? '0 : v;
            ACT_LEAKY: return v[BIAS_WIDTH-1] ? (v >>> LEAKY_SHIFT) : v;
            default:   return v;
        endcase
    endfunction

    logic                         en;
    logic signed [ACC_WIDTH-1:0]  tree_sum;
    logic                         tree_vld;
    logic signed [BIAS_WIDTH-1:0] biased;
    logic signed [DATA_WIDTH-1:0] act_sat;
    logic signed [DATA_WIDTH-1:0] act_p0;
    logic                         vld_p0;
    logic [CNT_W-1:0]             col;
    logic [CNT_W-1:0]             row;
    logic                         out_xfer;

    // A single enable freezes the whole pipe behind a stalled output, and
    // lets empty stages keep shifting so bubbles compress out.
    assign en        = !valid_out || ready_in;
    assign ready_out = en;
    assign out_xfer  = valid_out && ready_in;

    // ---- stages 1..L: adder tree ----
    adder_tree_pipe #(
        .NUM_IN   (NUM_CH),
        .IN_WIDTH (DATA_WIDTH)
    ) u_tree (
        .Clk       (Clk),
        .Rst       (Rst),
        .en        (en),
        .in_vec    (data_in),
        .in_valid  (valid_in),
        .sum       (tree_sum),
        .sum_valid (tree_vld)
    );

    always_comb begin
        biased  = BIAS_WIDTH'(tree_sum) + BIAS_WIDTH'(BIAS);
        act_sat = DATA_WIDTH'(sat_to_width(SAT_WIDTH'(apply_act(biased)), DATA_WIDTH));
    end

    // ---- stage L+1: bias, activation, saturation ----
    always_ff @(posedge Clk) begin
        if (en) begin
            act_p0 <= act_sat;
        end
    end

    // ---- stage L+2: output register ----
    always_ff @(posedge Clk) begin
        if (!Rst) begin
            vld_p0    <= 1'b0;
            valid_out <= 1'b0;
            data_out  <= '0;
        end else if (en) begin
            vld_p0    <= tree_vld;
            valid_out <= vld_p0;
            data_out  <= act_p0;
        end
    end

    // Pixel position of the word currently on data_out.
    always_ff @(posedge Clk) begin
        if (!Rst) begin
            col <= '0;
            row <= '0;
        end else if (out_xfer) begin
            if (col == LAST_POS) begin
                col <= '0;
                row <= (row == LAST_POS) ? '0 : row + CNT_W'(1);
            end else begin
                col <= col + CNT_W'(1);
            end
        end
    end

    assign row_end   = valid_out && (col == LAST_POS);
    assign frame_end = row_end && (row == LAST_POS);

endmodule

// File: tb/tb_layer_featuremap_reduce.sv
module tb_layer_featuremap_reduce;

    localparam int DW  = 16;
    localparam int NCH = 16;

    logic Clk = 1'b0;
    always #5 Clk = ~Clk;

    logic rst_n;

    // 16-channel bank, three activation variants sharing the same inputs
    logic [NCH*DW-1:0] din;
    logic              vin, rin;
    logic              rdy_lin, rdy_lky, rdy_rel;
    logic [DW-1:0]     out_lin, out_lky, out_rel;
    logic              vld_lin, vld_lky, vld_rel;
    logic              re_lin, re_lky, re_rel;
    logic              fe_lin, fe_lky, fe_rel;

    // 3-channel instance with bias
    logic [3*DW-1:0]   din3;
    logic              vin3, rin3, rdy3, vld3, re3, fe3;
    logic [DW-1:0]     out3;

    int vectors     = 0;
    int miscompares = 0;

    logic [NCH*DW-1:0] vec;

    layer_featuremap_reduce #(.NUM_CH(NCH), .DATA_WIDTH(DW), .FRAC_BITS(8), .IMG_SIZE(4),
                              .BIAS(16'sh0000), .ACT_MODE(0), .LEAKY_SHIFT(3)) u_lin (
        .Clk(Clk), .Rst(rst_n), .data_in(din), .valid_in(vin), .ready_out(rdy_lin),
        .data_out(out_lin), .valid_out(vld_lin), .ready_in(rin),
        .row_end(re_lin), .frame_end(fe_lin));

    layer_featuremap_reduce #(.NUM_CH(NCH), .DATA_WIDTH(DW), .FRAC_BITS(8), .IMG_SIZE(4),
                              .BIAS(16'sh0000), .ACT_MODE(1), .LEAKY_SHIFT(3)) u_lky (
        .Clk(Clk), .Rst(rst_n), .data_in(din), .valid_in(vin), .ready_out(rdy_lky),
        .data_out(out_lky), .valid_out(vld_lky), .ready_in(rin),
        .row_end(re_lky), .frame_end(fe_lky));

    layer_featuremap_reduce #(.NUM_CH(NCH), .DATA_WIDTH(DW), .FRAC_BITS(8), .IMG_SIZE(4),
                              .BIAS(16'sh0000), .ACT_MODE(2), .LEAKY_SHIFT(3)) u_rel (
        .Clk(Clk), .Rst(rst_n), .data_in(din), .valid_in(vin), .ready_out(rdy_rel),
        .data_out(out_rel), .valid_out(vld_rel), .ready_in(rin),
        .row_end(re_rel), .frame_end(fe_rel));

    layer_featuremap_reduce #(.NUM_CH(3), .DATA_WIDTH(DW), .FRAC_BITS(8), .IMG_SIZE(4),
                              .BIAS(16'sh0080), .ACT_MODE(1), .LEAKY_SHIFT(3)) u_odd (
        .Clk(Clk), .Rst(rst_n), .data_in(din3), .valid_in(vin3), .ready_out(rdy3),
        .data_out(out3), .valid_out(vld3), .ready_in(rin3),
        .row_end(re3), .frame_end(fe3));

    function automatic logic [NCH*DW-1:0] fill(input logic [DW-1:0] v);
        logic [NCH*DW-1:0] r;
        for (int k = 0; k < NCH; k++) r[k*DW +: DW] = v;
        return r;
    endfunction

    // Pixel id -> channel values (small, mixed sign)
    function automatic logic [NCH*DW-1:0] make_pix(input int id);
        logic [NCH*DW-1:0] r;
        for (int k = 0; k < NCH; k++) r[k*DW +: DW] = DW'(id * 5 - k * 3 + 11);
        return r;
    endfunction

    // Linear reference: integer sum, clamped to 16-bit signed
    function automatic logic [DW-1:0] model_lin(input int id);
        int s;
        s = 0;
        for (int k = 0; k < NCH; k++) s += id * 5 - k * 3 + 11;
        if (s > 32767) s = 32767;
        if (s < -32768) s = -32768;
        return DW'(s);
    endfunction

    task automatic test_reset();
        rst_n = 1'b0; vin = 1'b0; rin = 1'b0; din = '0;
        vin3 = 1'b0; rin3 = 1'b0; din3 = '0;
        repeat (3) @(posedge Clk);
        @(negedge Clk);
        rst_n = 1'b1;
        #1;
        vectors++; if (vld_lin !== 1'b0) begin miscompares++; $display("FAIL reset_valid_out: got %0b want 0", vld_lin); end
        vectors++; if (out_lin !== 16'h0000) begin miscompares++; $display("FAIL reset_data_out: got %h want 0000", out_lin); end
        vectors++; if (re_lin !== 1'b0 || fe_lin !== 1'b0) begin miscompares++; $display("FAIL reset_flags: got row_end=%0b frame_end=%0b want 0 0", re_lin, fe_lin); end
        vectors++; if (vld3 !== 1'b0 || out3 !== 16'h0000) begin miscompares++; $display("FAIL reset_odd: got valid=%0b data=%h want 0 0000", vld3, out3); end
        @(posedge Clk);
        @(negedge Clk);
        // ready_in is 0, so ready_out must come from an empty output register
        vectors++; if (rdy_lin !== 1'b1 || rdy3 !== 1'b1) begin miscompares++; $display("FAIL reset_ready_out: got %0b/%0b want 1/1", rdy_lin, rdy3); end
        rin = 1'b1; rin3 = 1'b1;
    endtask

    task automatic test_activation(input string name, input logic [NCH*DW-1:0] v,
                                   input logic [DW-1:0] e_lin, input logic [DW-1:0] e_lky,
                                   input logic [DW-1:0] e_rel);
        @(negedge Clk);
        din = v; vin = 1'b1; rin = 1'b1;
        @(posedge Clk);
        @(negedge Clk);
        vin = 1'b0; din = '0;
        repeat (4) @(posedge Clk);
        @(negedge Clk);
        vectors++; if (vld_lin !== 1'b0) begin miscompares++; $display("FAIL %s_early: valid_out at cycle 5 got %0b want 0", name, vld_lin); end
        @(posedge Clk);
        @(negedge Clk);
        vectors++; if (vld_lin !== 1'b1 || out_lin !== e_lin) begin miscompares++; $display("FAIL %s_linear: got valid=%0b data=%h want 1 %h", name, vld_lin, out_lin, e_lin); end
        vectors++; if (vld_lky !== 1'b1 || out_lky !== e_lky) begin miscompares++; $display("FAIL %s_leaky: got valid=%0b data=%h want 1 %h", name, vld_lky, out_lky, e_lky); end
        vectors++; if (vld_rel !== 1'b1 || out_rel !== e_rel) begin miscompares++; $display("FAIL %s_relu: got valid=%0b data=%h want 1 %h", name, vld_rel, out_rel, e_rel); end
    endtask

    task automatic test_odd_channels(input string name, input logic [3*DW-1:0] v, input logic [DW-1:0] e);
        @(negedge Clk);
        din3 = v; vin3 = 1'b1; rin3 = 1'b1;
        @(posedge Clk);
        @(negedge Clk);
        vin3 = 1'b0; din3 = '0;
        repeat (2) @(posedge Clk);
        @(negedge Clk);
        vectors++; if (vld3 !== 1'b0) begin miscompares++; $display("FAIL %s_early: valid_out at cycle 3 got %0b want 0", name, vld3); end
        @(posedge Clk);
        @(negedge Clk);
        vectors++; if (vld3 !== 1'b1 || out3 !== e) begin miscompares++; $display("FAIL %s: got valid=%0b data=%h want 1 %h", name, vld3, out3, e); end
    endtask

    task automatic test_backpressure();
        logic [DW-1:0] exp_q[$];
        logic [DW-1:0] prev_data;
        logic [DW-1:0] e;
        bit            prev_stall;
        int            sent, got;
        sent = 0; got = 0; prev_stall = 0; prev_data = '0;
        for (int cyc = 0; cyc < 400 && got < 20; cyc++) begin
            @(negedge Clk);
            rin = ($urandom_range(0, 2) != 0);
            vin = (sent < 20) && ($urandom_range(0, 3) != 0);
            din = make_pix(sent + 1);
            #1;
            if (prev_stall) begin
                vectors++;
                if (vld_lin !== 1'b1 || out_lin !== prev_data) begin miscompares++; $display("FAIL bp_hold: got valid=%0b data=%h want 1 %h", vld_lin, out_lin, prev_data); end
            end
            if (vld_lin && !rin) begin
                vectors++;
                if (rdy_lin !== 1'b0) begin miscompares++; $display("FAIL bp_ready_out: got %0b want 0 while stalled", rdy_lin); end
            end
            prev_stall = vld_lin && !rin;
            prev_data  = out_lin;
            if (vld_lin && rin) begin
                vectors++;
                if (exp_q.size() == 0) begin
                    miscompares++; $display("FAIL bp_extra_output: got %h want no output", out_lin);
                end else begin
                    e = exp_q.pop_front();
                    if (out_lin !== e) begin miscompares++; $display("FAIL bp_data[%0d]: got %h want %h", got, out_lin, e); end
                end
                got++;
            end
            if (vin && rdy_lin) begin
                exp_q.push_back(model_lin(sent + 1));
                sent++;
            end
        end
        @(negedge Clk);
        vin = 1'b0; rin = 1'b1;
        vectors++; if (got != 20) begin miscompares++; $display("FAIL bp_count: got %0d outputs want 20", got); end
    endtask

    task automatic test_frames();
        logic [DW-1:0] exp_q[$];
        logic [DW-1:0] e;
        logic          exp_re, exp_fe;
        int            sent, t, stray;

        @(negedge Clk);
        rst_n = 1'b0; vin = 1'b0; rin = 1'b1;
        @(posedge Clk);
        @(negedge Clk);
        rst_n = 1'b1;

        // Two full 4x4 frames back to back, then 9 pixels into the third
        sent = 0; t = 0;
        for (int cyc = 0; cyc < 100 && t < 41; cyc++) begin
            @(negedge Clk);
            vin = 1'b1; din = make_pix(sent + 50);
            #1;
            if (vld_lin) begin
                t++;
                exp_re = (t % 4 == 0);
                exp_fe = (t % 16 == 0);
                e = (exp_q.size() != 0) ? exp_q.pop_front() : 16'hxxxx;
                vectors++; if (out_lin !== e) begin miscompares++; $display("FAIL frame_data[%0d]: got %h want %h", t, out_lin, e); end
                vectors++; if (re_lin !== exp_re) begin miscompares++; $display("FAIL row_end[%0d]: got %0b want %0b", t, re_lin, exp_re); end
                vectors++; if (fe_lin !== exp_fe) begin miscompares++; $display("FAIL frame_end[%0d]: got %0b want %0b", t, fe_lin, exp_fe); end
            end
            if (vin && rdy_lin) begin
                exp_q.push_back(model_lin(sent + 50));
                sent++;
            end
        end
        vectors++; if (t != 41) begin miscompares++; $display("FAIL frame_count: got %0d outputs want 41", t); end

        // Reset lands on the edge that would complete the 10th transfer
        @(negedge Clk);
        rst_n = 1'b0;
        @(posedge Clk);
        @(negedge Clk);
        rst_n = 1'b1; vin = 1'b0; rin = 1'b0;
        #1;
        vectors++; if (vld_lin !== 1'b0 || out_lin !== 16'h0000) begin miscompares++; $display("FAIL midreset_out: got valid=%0b data=%h want 0 0000", vld_lin, out_lin); end
        vectors++; if (re_lin !== 1'b0 || fe_lin !== 1'b0 || rdy_lin !== 1'b1) begin miscompares++; $display("FAIL midreset_ctrl: got row_end=%0b frame_end=%0b ready_out=%0b want 0 0 1", re_lin, fe_lin, rdy_lin); end
        rin = 1'b1;
        stray = 0;
        for (int cyc = 0; cyc < 10; cyc++) begin
            @(negedge Clk);
            if (vld_lin) stray++;
        end
        vectors++; if (stray != 0) begin miscompares++; $display("FAIL midreset_flush: got %0d stray outputs want 0", stray); end

        // Fresh frame: counters must start from 0
        exp_q.delete();
        sent = 0; t = 0;
        for (int cyc = 0; cyc < 60 && t < 16; cyc++) begin
            @(negedge Clk);
            vin = (sent < 16); din = make_pix(sent + 200);
            #1;
            if (vld_lin) begin
                t++;
                exp_re = (t % 4 == 0);
                exp_fe = (t == 16);
                e = (exp_q.size() != 0) ? exp_q.pop_front() : 16'hxxxx;
                vectors++; if (out_lin !== e) begin miscompares++; $display("FAIL post_reset_data[%0d]: got %h want %h", t, out_lin, e); end
                vectors++; if (re_lin !== exp_re || fe_lin !== exp_fe) begin miscompares++; $display("FAIL post_reset_flags[%0d]: got row_end=%0b frame_end=%0b want %0b %0b", t, re_lin, fe_lin, exp_re, exp_fe); end
            end
            if (vin && rdy_lin) begin
                exp_q.push_back(model_lin(sent + 200));
                sent++;
            end
        end
        vectors++; if (t != 16) begin miscompares++; $display("FAIL post_reset_count: got %0d outputs want 16", t); end
        @(negedge Clk);
        vin = 1'b0;
    endtask

    initial begin
        test_reset();

        test_activation("ones",   fill(16'h0100), 16'h1000, 16'h1000, 16'h1000);
        test_activation("pos_sat", fill(16'h7FFF), 16'h7FFF, 16'h7FFF, 16'h7FFF);
        test_activation("neg_sat", fill(16'h8000), 16'h8000, 16'h8000, 16'h0000);
        vec = '0; vec[DW-1:0] = 16'hFF00;
        test_activation("neg_256", vec, 16'hFF00, 16'hFFE0, 16'h0000);
        vec = '0; vec[5*DW +: DW] = 16'hFFFF;
        test_activation("neg_1",   vec, 16'hFFFF, 16'hFFFF, 16'h0000);
        for (int k = 0; k < NCH - 1; k++) vec[k*DW +: DW] = DW'(k + 1);
        vec[(NCH-1)*DW +: DW] = 16'hFE00;
        test_activation("mixed",   vec, 16'hFE78, 16'hFFCF, 16'h0000);

        test_odd_channels("odd_bias_pos", {16'h0003, 16'h0002, 16'h0001}, 16'h0086);
        test_odd_channels("odd_bias_neg", {16'h0000, 16'hFF00, 16'hFF00}, 16'hFFD0);

        test_backpressure();
        test_frames();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
